// File: rtl/spi_load_decoder.sv
// spi_load_decoder
//   Turns the byte stream from the SPI slave deserializer into 32-bit memory
//   writes. The loader sends two kinds of command:
//     OP_ADDR + 4 address bytes (MSB first) : load the write address
//     OP_DATA + 4 data bytes    (MSB first) : write one word, then address += 4
//   Used to preload memories while the CPU is held in reset.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_byte_valid/i_byte received SPI byte strobe and value
//   i_frame_abort       cs_n rose mid-command: drop the partial command
//   o_wr_valid/o_wr_addr/o_wr_data/o_wr_strb, i_wr_ready
//                       memory write request (valid/ready handshake)
//   o_busy              parser is not idle
//   o_wr_count          accepted writes (wraps)
//   o_err_count         bad opcodes + overrun bytes (saturates)
//   o_err_misalign      sticky: a non word-aligned address was loaded
module spi_load_decoder #(
  parameter logic [7:0]  OP_ADDR    = 8'h01,
  parameter logic [7:0]  OP_DATA    = 8'h02,
  parameter logic [31:0] RESET_ADDR = 32'h4000_0000,
  parameter int          CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_byte_valid,
  input  logic [7:0]       i_byte,
  input  logic             i_frame_abort,
  output logic             o_wr_valid,
  output logic [31:0]      o_wr_addr,
  output logic [31:0]      o_wr_data,
  output logic [3:0]       o_wr_strb,
  input  logic             i_wr_ready,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_wr_count,
  output logic [7:0]       o_err_count,
  output logic             o_err_misalign
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_DATA  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [31:0]      addr_r, addr_s;
  logic [31:0]      shreg_r, shreg_s;
  logic [31:0]      shifted_s;
  logic [1:0]       cnt_r, cnt_s;
  logic             wr_valid_r, wr_valid_s;
  logic [31:0]      wr_addr_r, wr_addr_s;
  logic [31:0]      wr_data_r, wr_data_s;
  logic [3:0]       wr_strb_r, wr_strb_s;
  logic             busy_r, busy_s;
  logic [CNT_W-1:0] wr_count_r, wr_count_s;
  logic [7:0]       err_count_r, err_count_s;
  logic             err_mis_r, err_mis_s;
  logic             err_inc_s;

  // Saturating increment for the 8-bit error counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

  // Next-state and next-output logic for the command parser.
  always_comb begin
    state_s     = state_r;
    addr_s      = addr_r;
    shreg_s     = shreg_r;
    cnt_s       = cnt_r;
    wr_valid_s  = wr_valid_r;
    wr_addr_s   = wr_addr_r;
    wr_data_s   = wr_data_r;
    wr_strb_s   = wr_strb_r;
    wr_count_s  = wr_count_r;
    err_mis_s   = err_mis_r;
    err_inc_s   = 1'b0;
    shifted_s   = {shreg_r[23:0], i_byte};

    case (state_r)
      ST_IDLE: begin
        // Abort is meaningless here: no command is in progress.
        if (i_byte_valid) begin
          if (i_byte == OP_ADDR) begin
            state_s = ST_ADDR;
            cnt_s   = 2'd0;
          end else if (i_byte == OP_DATA) begin
            state_s = ST_DATA;
            cnt_s   = 2'd0;
          end else begin
            err_inc_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_ADDR, ST_DATA: begin
        // Abort has priority over a byte arriving in the same cycle.
        if (i_frame_abort) begin
          state_s = ST_IDLE;
          cnt_s   = 2'd0;
        end else if (i_byte_valid) begin
          shreg_s = shifted_s;
          cnt_s   = cnt_r + 2'd1;
          if (cnt_r == 2'd3) begin
            if (state_r == ST_ADDR) begin
              // Full address is kept; only the write port masks bits [1:0].
              addr_s  = shifted_s;
              state_s = ST_IDLE;
              if (shifted_s[1:0] != 2'b00) begin
                err_mis_s = 1'b1;
              end else begin
                err_mis_s = err_mis_r;
              end
            end else begin
              wr_valid_s = 1'b1;
              wr_addr_s  = {addr_r[31:2], 2'b00};
              wr_data_s  = shifted_s;
              wr_strb_s  = 4'hF;
              state_s    = ST_WRITE;
            end
          end else begin
            state_s = state_r;
          end
        end else begin
          state_s = state_r;
        end
      end

      ST_WRITE: begin
        // Any byte while a write is pending is an overrun and is dropped.
        if (i_byte_valid) begin
          err_inc_s = 1'b1;
        end else begin
          err_inc_s = 1'b0;
        end
        if (wr_valid_r && i_wr_ready) begin
          wr_valid_s = 1'b0;
          wr_strb_s  = 4'h0;
          addr_s     = addr_r + 32'd4;
          wr_count_s = wr_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
          state_s    = ST_IDLE;
        end else begin
          state_s = ST_WRITE;
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase

    if (err_inc_s) begin
      err_count_s = sat_inc8(err_count_r);
    end else begin
      err_count_s = err_count_r;
    end

    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r     <= ST_IDLE;
      addr_r      <= RESET_ADDR;
      shreg_r     <= 32'h0000_0000;
      cnt_r       <= 2'd0;
      wr_valid_r  <= 1'b0;
      wr_addr_r   <= 32'h0000_0000;
      wr_data_r   <= 32'h0000_0000;
      wr_strb_r   <= 4'h0;
      busy_r      <= 1'b0;
      wr_count_r  <= '0;
      err_count_r <= 8'h00;
      err_mis_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      addr_r      <= addr_s;
      shreg_r     <= shreg_s;
      cnt_r       <= cnt_s;
      wr_valid_r  <= wr_valid_s;
      wr_addr_r   <= wr_addr_s;
      wr_data_r   <= wr_data_s;
      wr_strb_r   <= wr_strb_s;
      busy_r      <= busy_s;
      wr_count_r  <= wr_count_s;
      err_count_r <= err_count_s;
      err_mis_r   <= err_mis_s;
    end
  end

  assign o_wr_valid     = wr_valid_r;
  assign o_wr_addr      = wr_addr_r;
  assign o_wr_data      = wr_data_r;
  assign o_wr_strb      = wr_strb_r;
  assign o_busy         = busy_r;
  assign o_wr_count     = wr_count_r;
  assign o_err_count    = err_count_r;
  assign o_err_misalign = err_mis_r;

endmodule

// File: tb/tb_spi_load_decoder.sv
// Bench for spi_load_decoder: a table of per-cycle vectors for the basic
// address+data sequence, hand-written multi-cycle sequences, and random
// traffic checked against a transaction-level model of the loader protocol.
module tb_spi_load_decoder;

  logic        i_clk;
  logic        i_rst;
  logic        i_byte_valid;
  logic [7:0]  i_byte;
  logic        i_frame_abort;
  logic        o_wr_valid;
  logic [31:0] o_wr_addr;
  logic [31:0] o_wr_data;
  logic [3:0]  o_wr_strb;
  logic        i_wr_ready;
  logic        o_busy;
  logic [15:0] o_wr_count;
  logic [7:0]  o_err_count;
  logic        o_err_misalign;

  spi_load_decoder dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_byte_valid   (i_byte_valid),
    .i_byte         (i_byte),
    .i_frame_abort  (i_frame_abort),
    .o_wr_valid     (o_wr_valid),
    .o_wr_addr      (o_wr_addr),
    .o_wr_data      (o_wr_data),
    .o_wr_strb      (o_wr_strb),
    .i_wr_ready     (i_wr_ready),
    .o_busy         (o_busy),
    .o_wr_count     (o_wr_count),
    .o_err_count    (o_err_count),
    .o_err_misalign (o_err_misalign)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int total;
  int bad;

  // ---------------- reference model (command-level) ----------------
  int          m_kind;   // 0: no command open, 1: address cmd, 2: data cmd
  int          m_got;    // payload bytes collected so far
  logic [31:0] m_acc;
  logic        m_pend;   // a write is waiting for ready
  logic [31:0] m_addr;
  logic [31:0] m_waddr;
  logic [31:0] m_wdata;
  logic [15:0] m_wcnt;
  int          m_err;
  logic        m_mis;

  task automatic model_reset();
    m_kind = 0; m_got = 0; m_acc = 32'h0; m_pend = 1'b0;
    m_addr = 32'h4000_0000; m_waddr = 32'h0; m_wdata = 32'h0;
    m_wcnt = 16'd0; m_err = 0; m_mis = 1'b0;
  endtask

  task automatic model_step(input logic bv, input logic [7:0] b,
                            input logic ab, input logic rdy);
    if (m_pend) begin
      if (bv) m_err = (m_err < 255) ? m_err + 1 : 255;
      if (rdy) begin
        m_pend = 1'b0;
        m_addr = m_addr + 32'd4;
        m_wcnt = m_wcnt + 16'd1;
      end
    end else if (m_kind == 0) begin
      if (bv) begin
        if (b == 8'h01) begin m_kind = 1; m_got = 0; end
        else if (b == 8'h02) begin m_kind = 2; m_got = 0; end
        else m_err = (m_err < 255) ? m_err + 1 : 255;
      end
    end else if (ab) begin
      m_kind = 0;
    end else if (bv) begin
      m_acc = (m_acc << 8) | {24'h0, b};
      m_got = m_got + 1;
      if (m_got == 4) begin
        if (m_kind == 1) begin
          m_addr = m_acc;
          if ((m_acc % 4) != 0) m_mis = 1'b1;
        end else begin
          m_pend  = 1'b1;
          m_waddr = m_addr - (m_addr % 4);
          m_wdata = m_acc;
        end
        m_kind = 0;
      end
    end
  endtask

  // ---------------- comparison helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"}, {31'h0, o_wr_valid}, {31'h0, m_pend});
    chk({tag, ".addr"},  o_wr_addr, m_waddr);
    chk({tag, ".data"},  o_wr_data, m_wdata);
    chk({tag, ".strb"},  {28'h0, o_wr_strb}, m_pend ? 32'hF : 32'h0);
    chk({tag, ".wcnt"},  {16'h0, o_wr_count}, {16'h0, m_wcnt});
    chk({tag, ".err"},   {24'h0, o_err_count}, m_err);
    chk({tag, ".mis"},   {31'h0, o_err_misalign}, {31'h0, m_mis});
    chk({tag, ".busy"},  {31'h0, o_busy}, {31'h0, (m_pend || (m_kind != 0))});
  endtask

  // One clock: drive inputs, advance model on the edge, check 1 ns later.
  task automatic step(input logic bv, input logic [7:0] b, input logic ab,
                      input logic rdy, input string tag);
    i_byte_valid = bv; i_byte = b; i_frame_abort = ab; i_wr_ready = rdy;
    @(posedge i_clk);
    model_step(bv, b, ab, rdy);
    #1;
    check_model(tag);
    i_byte_valid = 1'b0; i_frame_abort = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic rdy, input string tag);
    step(1'b1, b, 1'b0, rdy, tag);
  endtask

  task automatic send_word(input logic [7:0] op, input logic [31:0] w,
                           input logic rdy, input string tag);
    send(op, rdy, tag);
    for (int k = 3; k >= 0; k--) send(w[k*8 +: 8], rdy, tag);
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_byte_valid = 1'b0; i_frame_abort = 1'b0; i_wr_ready = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    model_reset();
    check_model("reset");
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic        bv;
    logic [7:0]  b;
    logic        ab;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    logic [15:0] e_wcnt;
    logic        e_busy;
  } vec_t;

  vec_t tbl[11];

  logic        r_bv, r_ab, r_rdy;
  logic [7:0]  r_b;

  initial begin
    total = 0; bad = 0;
    i_rst = 1'b1; i_byte_valid = 1'b0; i_byte = 8'h00;
    i_frame_abort = 1'b0; i_wr_ready = 1'b0;
    model_reset();

    tbl[0]  = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 16'd0, 1'b1};
    tbl[1]  = '{1'b1, 8'h40, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 16'd0, 1'b1};
    tbl[2]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 16'd0, 1'b1};
    tbl[3]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 16'd0, 1'b1};
    tbl[4]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 16'd0, 1'b0};
    tbl[5]  = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 16'd0, 1'b1};
    tbl[6]  = '{1'b1, 8'hDE, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 16'd0, 1'b1};
    tbl[7]  = '{1'b1, 8'hAD, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 16'd0, 1'b1};
    tbl[8]  = '{1'b1, 8'hBE, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 16'd0, 1'b1};
    tbl[9]  = '{1'b1, 8'hEF, 1'b0, 1'b1, 1'b1, 32'h4000_0000, 32'hDEAD_BEEF, 16'd0, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h4000_0000, 32'hDEAD_BEEF, 16'd1, 1'b0};

    @(posedge i_clk);
    #1;
    do_reset();
    chk("rst.valid", {31'h0, o_wr_valid}, 32'h0);
    chk("rst.addr", o_wr_addr, 32'h0);
    chk("rst.count", {16'h0, o_wr_count}, 32'h0);

    // Address load then data write, cycle by cycle.
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].bv, tbl[i].b, tbl[i].ab, tbl[i].rdy, "tbl");
      chk($sformatf("tbl%0d.valid", i), {31'h0, o_wr_valid}, {31'h0, tbl[i].e_valid});
      chk($sformatf("tbl%0d.addr", i), o_wr_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d.data", i), o_wr_data, tbl[i].e_data);
      chk($sformatf("tbl%0d.wcnt", i), {16'h0, o_wr_count}, {16'h0, tbl[i].e_wcnt});
      chk($sformatf("tbl%0d.busy", i), {31'h0, o_busy}, {31'h0, tbl[i].e_busy});
    end

    // Auto-increment.
    send_word(8'h02, 32'h1122_3344, 1'b1, "inc");
    chk("inc.addr1", o_wr_addr, 32'h4000_0004);
    step(1'b0, 8'h00, 1'b0, 1'b1, "inc");
    send_word(8'h02, 32'h5566_7788, 1'b1, "inc");
    chk("inc.addr2", o_wr_addr, 32'h4000_0008);
    chk("inc.data2", o_wr_data, 32'h5566_7788);
    step(1'b0, 8'h00, 1'b0, 1'b1, "inc");
    chk("inc.count", {16'h0, o_wr_count}, 32'd3);

    // Back-pressure with one overrun byte during the stall.
    send_word(8'h02, 32'hCAFE_F00D, 1'b0, "bp");
    for (int c = 0; c < 20; c++) begin
      step((c == 5), 8'h02, 1'b0, 1'b0, "bp");
      chk("bp.valid", {31'h0, o_wr_valid}, 32'h1);
      chk("bp.addr", o_wr_addr, 32'h4000_000C);
      chk("bp.data", o_wr_data, 32'hCAFE_F00D);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1, "bp");
    chk("bp.done", {31'h0, o_wr_valid}, 32'h0);
    chk("bp.count", {16'h0, o_wr_count}, 32'd4);
    chk("bp.err", {24'h0, o_err_count}, 32'd1);

    // Bad opcode, then aborted address command.
    do_reset();
    send(8'h7F, 1'b1, "abt");
    send(8'h01, 1'b1, "abt");
    send(8'h20, 1'b1, "abt");
    send(8'h00, 1'b1, "abt");
    step(1'b1, 8'h00, 1'b1, 1'b1, "abt");   // abort beats the byte
    chk("abt.busy", {31'h0, o_busy}, 32'h0);
    send_word(8'h02, 32'h0000_0001, 1'b1, "abt");
    chk("abt.addr", o_wr_addr, 32'h4000_0000);
    chk("abt.data", o_wr_data, 32'h0000_0001);
    chk("abt.err", {24'h0, o_err_count}, 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1, "abt");

    // Misaligned address and wrap-around.
    send_word(8'h01, 32'hFFFF_FFFE, 1'b1, "mis");
    chk("mis.flag", {31'h0, o_err_misalign}, 32'h1);
    send_word(8'h02, 32'hAABB_CCDD, 1'b1, "mis");
    chk("mis.addr", o_wr_addr, 32'hFFFF_FFFC);
    step(1'b0, 8'h00, 1'b0, 1'b1, "mis");
    send_word(8'h02, 32'h0102_0304, 1'b1, "wrap");
    chk("wrap.addr", o_wr_addr, 32'h0000_0000);
    step(1'b0, 8'h00, 1'b0, 1'b1, "wrap");

    // Reset while a write is stalled.
    send_word(8'h02, 32'h1234_5678, 1'b0, "rstw");
    chk("rstw.pend", {31'h0, o_wr_valid}, 32'h1);
    do_reset();
    chk("rstw.valid", {31'h0, o_wr_valid}, 32'h0);
    chk("rstw.busy", {31'h0, o_busy}, 32'h0);
    chk("rstw.mis", {31'h0, o_err_misalign}, 32'h0);
    chk("rstw.err", {24'h0, o_err_count}, 32'h0);
    send_word(8'h02, 32'h8765_4321, 1'b1, "rstw");
    chk("rstw.addr", o_wr_addr, 32'h4000_0000);
    step(1'b0, 8'h00, 1'b0, 1'b1, "rstw");

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      if (n == 2000) do_reset();
      r_bv = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0: r_b = 8'h01;
        1: r_b = 8'h02;
        default: r_b = 8'($urandom);
      endcase
      r_ab = ($urandom_range(0, 29) == 0);
      if (r_ab && r_bv && (m_kind == 0) && !m_pend) r_ab = 1'b0;
      r_rdy = ($urandom_range(0, 3) != 0);
      step(r_bv, r_b, r_ab, r_rdy, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_load_decoder.md
Name: spi_load_decoder

Overview:
- Sits between the on-chip SPI slave byte deserializer and the memory write port of core_top.
- Parses the byte command stream from the external loader: opcode 0x01 followed by 4 address bytes, MSB first; opcode 0x02 followed by 4 data bytes, MSB first.
- Issues one 32-bit write per data command to the latched address, then auto-increments that address by 4.
- Used to preload instruction memory at 0x4000_0000 and the PIM buffer at 0x2000_0000 while the CPU is held in reset.

Parameters:
- OP_ADDR, 8'h01, opcode that loads the address register.
- OP_DATA, 8'h02, opcode that loads a data word and triggers a write.
- RESET_ADDR, 32'h4000_0000, address register value after reset.
- CNT_W, 16, width of the write counter.

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  synchronous active-high reset.
- i_byte_valid  input  1  one-cycle strobe: a received SPI byte is available.
- i_byte  input  8  received SPI byte.
- i_frame_abort  input  1  one-cycle strobe on cs_n rising while a command is incomplete; returns the parser to IDLE.
- o_wr_valid  output  1  write request valid.
- o_wr_addr  output  32  word-aligned write address.
- o_wr_data  output  32  write data.
- o_wr_strb  output  4  byte strobes; always 4'hF while o_wr_valid=1.
- i_wr_ready  input  1  memory accepts the write.
- o_busy  output  1  high in any state other than IDLE.
- o_wr_count  output  CNT_W  number of accepted writes; wraps.
- o_err_count  output  8  count of bad opcodes plus overruns; saturates at 8'hFF.
- o_err_misalign  output  1  sticky flag: an address with addr[1:0]!=0 was loaded.

Behaviour:
- Reset: state=IDLE; addr=RESET_ADDR; shift register=0; byte counter=0.
- All outputs reset to 0, including o_wr_addr and o_wr_data.
- IDLE on a byte:
  - byte==OP_ADDR: go to ADDR, counter=0.
  - byte==OP_DATA: go to DATA, counter=0.
  - any other byte: stay in IDLE, o_err_count+1.
- ADDR: each byte shifts in as shreg={shreg[23:0],byte}, counter+1.
  - On the 4th byte, load addr from the shift result in the same cycle and go to IDLE.
  - If the loaded addr[1:0]!=0, set o_err_misalign. The stored address keeps bits [1:0]; o_wr_addr drives {addr[31:2],2'b00}.
- DATA: same shifting as ADDR.
  - On the 4th byte, latch o_wr_data, drive o_wr_addr from addr, assert o_wr_valid the next cycle, and go to WRITE.
- WRITE: o_wr_valid, o_wr_addr and o_wr_data are held stable until i_wr_ready=1 is sampled with o_wr_valid=1.
  - On that edge: o_wr_valid=0, addr=addr+4 (wraps modulo 2^32), o_wr_count+1, go to IDLE.
  - Minimum latency from the 4th data byte strobe to o_wr_valid is 1 cycle. With i_wr_ready tied high, the write completes in the cycle after that.
- Overrun: a byte arriving in WRITE is dropped and o_err_count+1; the pending write is unaffected.
  - If i_wr_ready and i_byte_valid are both high in the same WRITE cycle, the write completes and the byte is still dropped (counted as overrun).
- i_frame_abort in ADDR or DATA: go to IDLE; partial bytes are discarded; addr is unchanged; no error counted.
  - In IDLE the abort is ignored.
  - In WRITE the abort is ignored; the write completes normally.
  - If abort and a byte arrive in the same cycle, the abort wins and the byte is discarded.
- i_rst mid-operation: any pending write is abandoned; o_wr_valid drops in the cycle after reset is sampled; counters and the sticky flag clear.
- The shift counter is 2 bits. Data and address bytes are never interpreted as opcodes.

Test Plan:
- Address load then data write: bytes 01 40 00 00 00 02 DE AD BE EF with ready=1 -> exactly one write, addr=0x4000_0000, data=0xDEADBEEF, strb=F; o_wr_count=1.
- Auto-increment: from the previous state, send 02 11 22 33 44 then 02 55 66 77 88 -> writes at 0x4000_0004 and 0x4000_0008; o_wr_count=3.
- Back-pressure: hold ready=0 for 20 cycles after the data word, and inject 1 byte during the stall -> o_wr_valid, addr and data stable for all 20 cycles; one write on release; o_err_count=1.
- Bad opcode and abort: send 7F, then 01 20 00 followed by abort, then 02 00 00 00 01 -> o_err_count=1; write lands at the previous addr (0x4000_0000 after reset), not at 0x2000_xxxx.
- Misalign and wrap: 01 FF FF FF FE, then 02 x4 -> o_err_misalign=1; o_wr_addr=0xFFFF_FFFC; next addr=0x0000_0002, so the next write targets 0x0000_0000.
- Reset in WRITE with ready=0 -> o_wr_valid=0 the next cycle; state IDLE; addr=0x4000_0000; counters 0.
